dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store port.
- Accepts word requests from the pipeline's memory stage (mem_addr, mem_wdata, mem_read, mem_write) and services them from an internal synchronous RAM after a configurable latency.
- Drives the stall back into the core's stall_in while an access is in flight, and returns mem_rdata on completion.
- Sits beside the pipeline in the SoC top level, replacing an ideal zero-latency data memory.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- LATENCY, 2: wait cycles between accept and RAM access; legal range 1..15.
- IDX_W, $clog2(DEPTH_WORDS): word-index width, derived.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_addr  in  32  byte address from the core.
- mem_wdata  in  32  store data.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- mem_rdata  out  32  load data to the core.
- stall  out  1  to the core's stall_in; high while an access is pending.
- err  out  1  one-cycle pulse on completion of a malformed request.

Behaviour:
- Reset values: state IDLE, stall 0, mem_rdata 0, err 0, wait counter 0. RAM contents are not reset.
- Request: req = mem_read | mem_write.
- Stall is combinational: stall = (state==IDLE & req) | (state==WAIT).
- FSM IDLE:
  - If req: latch addr index addr[IDX_W+1:2], wdata, op (write if mem_write), err flag; cnt <= LATENCY-1; go to WAIT.
  - Else stay in IDLE.
- FSM WAIT:
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: issue RAM access with latched index. A store writes wdata; a load reads. Go to DONE.
- FSM DONE:
  - stall 0.
  - Load: mem_rdata = RAM output, captured into a hold register this cycle.
  - err = latched err flag.
  - Go to IDLE unconditionally.
  - The request still presented this cycle belongs to the completing access and is consumed; it is not re-accepted.
- Timing: a request first presented at cycle T gives stall high T..T+LATENCY (LATENCY+1 cycles) and stall low with valid data at T+LATENCY+1.
- Back-to-back: a new request presented in the cycle after DONE is accepted in IDLE. The minimum period per access is LATENCY+2 cycles.
- mem_rdata holds the last completed load value until the next load completes. Stores do not change mem_rdata.
- Malformed request: mem_read & mem_write together, or addr[1:0] != 0.
  - The access is still performed: write wins over read; the address is word-aligned by dropping bits [1:0].
  - err pulses for exactly one cycle, in DONE.
- Out-of-range address: upper bits above IDX_W+1 are ignored, so addresses wrap modulo DEPTH_WORDS*4. err is not asserted.
- Requester rule: mem_addr, mem_wdata and op must stay stable while stall is high. The responder uses only the values latched at accept.
- Reset during WAIT: the access is abandoned, no RAM write occurs, stall drops to 0 in the next cycle.
- Reset during DONE: mem_rdata returns to 0.

Decomposition:
- Shared package dmem_pkg:
  - state enum: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - WORD_W=32.
  - MAX_LATENCY=15.
  - Counter width 4.
- One sub-module dmem_array:
  - Single-port synchronous RAM with parameter DEPTH_WORDS.
  - Ports: clk, we, idx, wdata, rdata.
  - Read-first; registered read data one cycle after the access.

Test Plan:
- Reset then idle: hold reset 2 cycles, no requests -> stall 0, mem_rdata 0, err 0 every cycle.
- Store then load, LATENCY=2:
  - Write 0xDEADBEEF to 0x40 at T -> stall high T..T+2, low at T+3.
  - Read 0x40 at T+4 -> stall T+4..T+6; mem_rdata=0xDEADBEEF at T+7 and held after.
- Back-to-back loads: read 0x40 then 0x44 (preloaded 0x11111111, 0x22222222), second request presented the cycle after DONE -> values returned in order with no extra stall cycles beyond LATENCY+1 each.
- Malformed request: mem_read=mem_write=1, addr=0x43, wdata=0xA5A5A5A5 -> word 0x40 written, err high only in the DONE cycle; a following read of 0x40 returns 0xA5A5A5A5 with err 0.
- Wrap: DEPTH_WORDS=1024, write 0x1 to 0x1000 -> a read of 0x0 returns 0x1.
- Reset mid-access: write 0x55 to 0x80, assert reset during WAIT -> stall 0 the next cycle; a read of 0x80 returns its prior value, not 0x55.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by the responder top and its RAM array.
package dmem_pkg;

  localparam int WORD_W      = 32;
  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, read-first.
// Read data is registered and appears one cycle after the access.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a load/store, stalls the core for
// LATENCY cycles, then accesses the RAM and returns data or err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              stall,
  output logic              err
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] hold;
  logic [WORD_W-1:0] ram_rdata;
  logic              wr_q;
  logic              bad_q;
  logic              req;
  logic              bad_in;
  logic              ram_we;
  logic              unused_addr;

  assign req    = mem_read | mem_write;
  assign bad_in = (mem_read & mem_write)
                | (mem_addr[1:0] != 2'b00);

  // Upper address bits wrap; they are deliberately ignored.
  assign unused_addr = ^mem_addr[WORD_W-1:IDX_W+2];

  // Reset in the last WAIT cycle must abandon the store.
  assign ram_we = (state == WAIT) && (cnt == '0)
                && wr_q && !reset;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      hold    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= mem_addr[IDX_W+1:2];
            wdata_q <= mem_wdata;
            wr_q    <= mem_write;
            bad_q   <= bad_in;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!wr_q) begin
            hold <= ram_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = ((state == IDLE) && req)
               || (state == WAIT);

  assign err = (state == DONE) && bad_q;

  assign mem_rdata = ((state == DONE) && !wr_q)
                   ? ram_rdata : hold;

endmodule
